// File: rtl/xcom_link_tx_ml.sv
// rtl/xcom_link_tx_ml.sv - multi-lane source-synchronous frame serializer
//
// Purpose: accepts one frame (8-bit header + 0/8/16/32-bit payload + optional
// even parity) per valid/ready handshake and shifts it out MSB first over
// NLANE data lanes, one symbol per 2H clock cycles. A strobe toggles in the
// middle of every symbol. Each frame is followed by a 2H-cycle idle gap.
//
// Ports:
//   x_clk_i      block clock, rising edge
//   x_rst_i      synchronous active-high reset
//   tick_cfg_i   half-symbol period H in clocks (0 behaves as 1)
//   tx_vld_i     frame request valid
//   tx_rdy_o     block idle and able to accept a frame
//   tx_header_i  frame header; [6:5] selects payload length
//   tx_data_i    payload, low L bits sent
//   tx_dt_o      serial data lanes, earliest bit on the top lane
//   tx_ck_o      strobe, one toggle per symbol
//   tx_done_o    one-cycle pulse per completed frame
//   tx_cnt_o     completed frame counter, wraps

module xcom_link_tx_ml #(
  parameter int NLANE     = 1,
  parameter int TICK_W    = 4,
  parameter int PARITY_EN = 1
) (
  input  logic              x_clk_i,
  input  logic              x_rst_i,
  input  logic [TICK_W-1:0] tick_cfg_i,
  input  logic              tx_vld_i,
  output logic              tx_rdy_o,
  input  logic [7:0]        tx_header_i,
  input  logic [31:0]       tx_data_i,
  output logic [NLANE-1:0]  tx_dt_o,
  output logic              tx_ck_o,
  output logic              tx_done_o,
  output logic [15:0]       tx_cnt_o
);

  // Longest frame is 41 bits; 48 leaves room for tail padding at any lane count.
  localparam int SR_W  = 48;
  localparam int PH_W  = TICK_W + 1;
  localparam int CNT_W = 7;
  localparam int LG_NL = $clog2(NLANE);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP
  } state_t;

  state_t            state_q;
  logic [SR_W-1:0]   sr_q;
  logic [PH_W-1:0]   ph_q;
  logic [TICK_W-1:0] h_q;
  logic [CNT_W-1:0]  sym_left_q;
  logic              rdy_q;
  logic              ck_q;
  logic              done_q;
  logic [NLANE-1:0]  dt_q;
  logic [15:0]       cnt_q;

  logic [31:0]       pay_al_d;
  logic              par_d;
  logic [SR_W-1:0]   stream_d;
  logic [CNT_W-1:0]  n_bits_d;
  logic [CNT_W-1:0]  sym_cnt_d;
  logic [TICK_W-1:0] h_d;
  logic [PH_W-1:0]   h_ext;
  logic [PH_W-1:0]   two_h;

  // Build the whole frame left-aligned so the shift register just pops
  // NLANE bits off the top for each symbol; zeros shifted in form the pad.
  always_comb begin
    pay_al_d = '0;
    n_bits_d = 7'd8;
    case (tx_header_i[6:5])
      2'b01: begin
        pay_al_d = {tx_data_i[7:0], 24'h0};
        n_bits_d = 7'd16;
      end
      2'b10: begin
        pay_al_d = {tx_data_i[15:0], 16'h0};
        n_bits_d = 7'd24;
      end
      2'b11: begin
        pay_al_d = tx_data_i;
        n_bits_d = 7'd40;
      end
      default: begin
        pay_al_d = '0;
        n_bits_d = 7'd8;
      end
    endcase
    par_d    = (^tx_header_i) ^ (^pay_al_d);
    stream_d = {tx_header_i, pay_al_d, 8'h00};
    if (PARITY_EN != 0) begin
      // Parity lands right after the last payload bit.
      case (tx_header_i[6:5])
        2'b01:   stream_d[31] = par_d;
        2'b10:   stream_d[23] = par_d;
        2'b11:   stream_d[7]  = par_d;
        default: stream_d[39] = par_d;
      endcase
      n_bits_d = n_bits_d + 7'd1;
    end
    sym_cnt_d = (n_bits_d + CNT_W'(NLANE - 1)) >> LG_NL;
    h_d       = (tick_cfg_i == '0) ? TICK_W'(1) : tick_cfg_i;
  end

  assign h_ext = {1'b0, h_q};
  assign two_h = {h_q, 1'b0};

  always_ff @(posedge x_clk_i) begin
    if (x_rst_i) begin
      state_q    <= ST_IDLE;
      sr_q       <= '0;
      ph_q       <= '0;
      h_q        <= TICK_W'(1);
      sym_left_q <= '0;
      rdy_q      <= 1'b0;
      ck_q       <= 1'b0;
      done_q     <= 1'b0;
      dt_q       <= '0;
      cnt_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          rdy_q <= 1'b1;
          if (tx_vld_i && rdy_q) begin
            state_q    <= ST_SEND;
            rdy_q      <= 1'b0;
            dt_q       <= stream_d[SR_W-1 -: NLANE];
            sr_q       <= stream_d << NLANE;
            h_q        <= h_d;
            ph_q       <= '0;
            sym_left_q <= sym_cnt_d - 7'd1;
          end
        end
        ST_SEND: begin
          ph_q <= ph_q + PH_W'(1);
          // Strobe edge falls in the middle of the symbol.
          if (ph_q == h_ext - PH_W'(1)) begin
            ck_q <= ~ck_q;
          end
          if (ph_q == two_h - PH_W'(1)) begin
            ph_q <= '0;
            if (sym_left_q == '0) begin
              state_q <= ST_GAP;
              dt_q    <= '0;
              done_q  <= 1'b1;
              cnt_q   <= cnt_q + 16'd1;
            end else begin
              dt_q       <= sr_q[SR_W-1 -: NLANE];
              sr_q       <= sr_q << NLANE;
              sym_left_q <= sym_left_q - 7'd1;
            end
          end
        end
        ST_GAP: begin
          ph_q <= ph_q + PH_W'(1);
          if (ph_q == two_h - PH_W'(1)) begin
            ph_q    <= '0;
            state_q <= ST_IDLE;
            rdy_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_rdy_o  = rdy_q;
  assign tx_dt_o   = dt_q;
  assign tx_ck_o   = ck_q;
  assign tx_done_o = done_q;
  assign tx_cnt_o  = cnt_q;

endmodule

// File: tb/tb_xcom_link_tx_ml.sv
// tb/tb_xcom_link_tx_ml.sv - scoreboard bench for xcom_link_tx_ml at 1, 2 and 4 lanes

module tb_xcom_link_tx_ml;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  tick_s = 4'd0;
  logic [7:0]  hdr_s = 8'h00;
  logic [31:0] data_s = 32'h0;
  logic        vld [3];
  logic        rdy_w [3];
  logic        ck_w [3];
  logic        done_w [3];
  logic [15:0] cnt_w [3];
  logic [3:0]  dt_w [3];

  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  // Entries are cycle*16 + symbol for strobe events, cycle for done events.
  int          sym_q [3][$];
  int          done_q [3][$];
  int          exp_rdy [3];
  bit          rdy_known [3];
  logic [15:0] model_cnt [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int NL = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    logic [NL-1:0] dt_loc;
    logic          prev_ck;

    xcom_link_tx_ml #(.NLANE(NL), .TICK_W(4), .PARITY_EN(1)) u_dut (
      .x_clk_i    (clk),
      .x_rst_i    (rst),
      .tick_cfg_i (tick_s),
      .tx_vld_i   (vld[g]),
      .tx_rdy_o   (rdy_w[g]),
      .tx_header_i(hdr_s),
      .tx_data_i  (data_s),
      .tx_dt_o    (dt_loc),
      .tx_ck_o    (ck_w[g]),
      .tx_done_o  (done_w[g]),
      .tx_cnt_o   (cnt_w[g])
    );
    assign dt_w[g] = 4'(dt_loc);

    always @(posedge clk) begin
      int e;
      #1;
      if (rst) begin
        prev_ck = ck_w[g];
      end else begin
        if (ck_w[g] !== prev_ck) begin
          prev_ck = ck_w[g];
          check($sformatf("ck_expected_l%0d", NL), 32'(sym_q[g].size() != 0), 1);
          if (sym_q[g].size() != 0) begin
            e = sym_q[g].pop_front();
            check($sformatf("sym_l%0d", NL), 32'(dt_w[g]), e % 16);
            check($sformatf("ck_cyc_l%0d", NL), cyc, e / 16);
          end
        end
        if (done_w[g]) begin
          check($sformatf("done_expected_l%0d", NL), 32'(done_q[g].size() != 0), 1);
          if (done_q[g].size() != 0) begin
            e = done_q[g].pop_front();
            check($sformatf("done_cyc_l%0d", NL), cyc, e);
            check($sformatf("sym_left_l%0d", NL), sym_q[g].size(), 0);
            check($sformatf("gap_dt_l%0d", NL), 32'(dt_w[g]), 0);
            model_cnt[g] = model_cnt[g] + 16'd1;
            check($sformatf("cnt_l%0d", NL), 32'(cnt_w[g]), 32'(model_cnt[g]));
          end
        end
      end
    end
  end

  // Independent frame model: flat bit list, then deal bits onto lanes.
  function automatic void push_frame(input int g, input logic [7:0] hdr, input logic [31:0] data,
                                     input int tick, input int acc);
    int nl;
    int len;
    int h;
    int s;
    bit par;
    bit bits [$];
    logic [3:0] sym;
    nl  = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    len = (hdr[6:5] == 2'd0) ? 0 : (hdr[6:5] == 2'd1) ? 8 : (hdr[6:5] == 2'd2) ? 16 : 32;
    h   = (tick == 0) ? 1 : tick;
    par = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      bits.push_back(hdr[i]);
      par ^= hdr[i];
    end
    for (int i = len - 1; i >= 0; i--) begin
      bits.push_back(data[i]);
      par ^= data[i];
    end
    bits.push_back(par);
    s = (bits.size() + nl - 1) / nl;
    while (bits.size() < s * nl) bits.push_back(1'b0);
    for (int k = 0; k < s; k++) begin
      sym = 4'h0;
      for (int j = 0; j < nl; j++) sym[nl-1-j] = bits[k*nl+j];
      sym_q[g].push_back((acc + 2*k*h + h) * 16 + int'(sym));
    end
    done_q[g].push_back(acc + 2*s*h);
    exp_rdy[g]   = acc + 2*s*h + 2*h;
    rdy_known[g] = 1'b1;
  endfunction

  // Called and returns at a falling edge. acc is the cycle just after acceptance.
  task automatic send(input int g, input logic [7:0] hdr, input logic [31:0] data,
                      input int tick, input bit hold);
    int t;
    int acc;
    hdr_s  = hdr;
    data_s = data;
    tick_s = 4'(tick);
    vld[g] = 1'b1;
    t = 0;
    while (!rdy_w[g] && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check($sformatf("rdy_wait_%0d", g), 32'(rdy_w[g]), 1);
    if (!rdy_w[g]) begin
      vld[g] = 1'b0;
      return;
    end
    if (t > 0 && rdy_known[g]) check($sformatf("rdy_cyc_%0d", g), cyc, exp_rdy[g]);
    rdy_known[g] = 1'b0;
    @(posedge clk);
    #1;
    acc = cyc;
    push_frame(g, hdr, data, tick, acc);
    @(negedge clk);
    if (!hold) vld[g] = 1'b0;
  endtask

  task automatic drain(input int g);
    int t;
    bit saw_low;
    t = 0;
    saw_low = 1'b0;
    while ((done_q[g].size() != 0 || !rdy_w[g]) && t < 3000) begin
      if (!rdy_w[g]) saw_low = 1'b1;
      @(negedge clk);
      t++;
    end
    check($sformatf("drain_%0d", g), 32'(rdy_w[g] && done_q[g].size() == 0), 1);
    if (saw_low && rdy_known[g]) check($sformatf("rdy_cyc_%0d", g), cyc, exp_rdy[g]);
    rdy_known[g] = 1'b0;
  endtask

  task automatic clear_model();
    for (int g = 0; g < 3; g++) begin
      sym_q[g].delete();
      done_q[g].delete();
      rdy_known[g] = 1'b0;
      model_cnt[g] = 16'h0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int g = 0; g < 3; g++) vld[g] = 1'b0;
    clear_model();

    // Reset state.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      check($sformatf("rst_rdy_%0d", g), 32'(rdy_w[g]), 0);
      check($sformatf("rst_dt_%0d", g), 32'(dt_w[g]), 0);
      check($sformatf("rst_ck_%0d", g), 32'(ck_w[g]), 0);
      check($sformatf("rst_done_%0d", g), 32'(done_w[g]), 0);
      check($sformatf("rst_cnt_%0d", g), 32'(cnt_w[g]), 0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) check($sformatf("rdy_after_rst_%0d", g), 32'(rdy_w[g]), 1);
    @(negedge clk);

    // Back-to-back frames with vld held, tick changed while a frame is in flight.
    send(0, 8'h9A, 32'h0, 1, 1'b1);
    repeat (4) @(negedge clk);
    tick_s = 4'd7;
    send(0, 8'h9A, 32'h0, 7, 1'b1);
    send(0, 8'h9A, 32'h0, 2, 1'b0);
    drain(0);
    check("b2b_cnt", 32'(cnt_w[0]), 3);

    // 1 lane, H=2, 17-bit frame ending in parity 1.
    send(0, 8'hAA, 32'h08, 2, 1'b0);
    drain(0);

    // 4 lanes, 32-bit payload, tail padded.
    send(2, 8'hEA, 32'h28, 2, 1'b0);
    drain(2);
    check("l4_cnt", 32'(cnt_w[2]), 1);

    // 2 lanes, tick 0 behaves as 1.
    send(1, 8'h80, 32'h0, 0, 1'b0);
    drain(1);

    // Random frames on every lane count.
    for (int g = 0; g < 3; g++) begin
      for (int i = 0; i < 5; i++) begin
        send(g, 8'($urandom_range(0, 255)), $urandom, int'($urandom_range(0, 3)),
             (i < 4) ? 1'($urandom_range(0, 1)) : 1'b0);
      end
      drain(g);
    end

    // Reset in symbol 5 of a 1-lane H=2 frame aborts it.
    send(0, 8'hAA, 32'h08, 2, 1'b0);
    repeat (21) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    clear_model();
    check("abort_rdy", 32'(rdy_w[0]), 0);
    check("abort_dt", 32'(dt_w[0]), 0);
    check("abort_ck", 32'(ck_w[0]), 0);
    check("abort_done", 32'(done_w[0]), 0);
    check("abort_cnt", 32'(cnt_w[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("abort_rdy_release", 32'(rdy_w[0]), 1);
    repeat (100) @(negedge clk);
    check("abort_cnt_after", 32'(cnt_w[0]), 0);
    check("abort_rdy_idle", 32'(rdy_w[0]), 1);

    // Counter wrap from 0xFFFF.
    force g_dut[1].u_dut.cnt_q = 16'hFFFF;
    @(negedge clk);
    release g_dut[1].u_dut.cnt_q;
    model_cnt[1] = 16'hFFFF;
    check("cnt_preload", 32'(cnt_w[1]), 32'hFFFF);
    send(1, 8'h80, 32'h0, 0, 1'b0);
    drain(1);
    check("cnt_wrap", 32'(cnt_w[1]), 0);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/xcom_link_tx_ml.md
XCOM_LINK_TX_ML -- requirements
Module: xcom_link_tx_ml

Interface
REQ-001 Parameter NLANE, default 1, number of serial data lanes; legal values 1, 2, 4.
REQ-002 Parameter TICK_W, default 4, width of tick_cfg_i.
REQ-003 Parameter PARITY_EN, default 1; 1 appends one even-parity bit per frame, 0 omits it.
REQ-004 x_clk_i  in  1  single block clock; all logic on rising edge.
REQ-005 x_rst_i  in  1  reset; synchronous, active-high.
REQ-006 tick_cfg_i  in  TICK_W  half-symbol period H in x_clk_i cycles; value 0 treated as 1.
REQ-007 tx_vld_i  in  1  frame request valid.
REQ-008 tx_rdy_o  out  1  block can accept a frame.
REQ-009 tx_header_i  in  8  frame header; bits [6:5] select payload length L: 00=0, 01=8, 10=16, 11=32 bits.
REQ-010 tx_data_i  in  32  payload; bits [L-1:0] sent, upper bits ignored.
REQ-011 tx_dt_o  out  NLANE  serial data lanes.
REQ-012 tx_ck_o  out  1  source-synchronous strobe; one toggle per symbol.
REQ-013 tx_done_o  out  1  one-cycle pulse per completed frame.
REQ-014 tx_cnt_o  out  16  count of completed frames.

Function
REQ-015 Handshake: frame accepted on a rising edge with tx_vld_i=1 and tx_rdy_o=1 (cycle A); header, data, L and H captured then; tx_rdy_o low from A+1.
REQ-016 Input changes after acceptance, including tick_cfg_i, do not affect the frame in flight.
REQ-017 Frame bit stream, MSB first: header[7:0], data[L-1:0], then parity bit (XOR of all header and payload bits) when PARITY_EN=1; length N=8+L+PARITY_EN.
REQ-018 Symbols: S=ceil(N/NLANE); symbol k carries stream bits k*NLANE..k*NLANE+NLANE-1, earliest bit on lane NLANE-1; missing tail bits padded with 0.
REQ-019 FSM states IDLE, SEND, GAP; IDLE->SEND on acceptance; SEND->GAP after last symbol; GAP->IDLE after 2H cycles.
REQ-020 tx_rdy_o=1 only in IDLE.
REQ-021 Symbol k held on tx_dt_o for cycles A+1+2kH through A+2(k+1)H inclusive.
REQ-022 tx_ck_o toggles once per symbol, on the edge entering cycle A+1+2kH+H (mid-symbol); receiver samples both edges.
REQ-023 tx_ck_o holds its last level between frames (no return-to-zero); tx_dt_o=0 in IDLE and GAP.
REQ-024 tx_done_o=1 for exactly the first GAP cycle, A+1+2SH.
REQ-025 tx_cnt_o increments with tx_done_o; wraps 0xFFFF->0x0000.
REQ-026 tx_rdy_o rises at cycle A+1+2SH+2H; tx_vld_i held high starts the next frame on that cycle (back-to-back, gap exactly 2H cycles).
REQ-027 tx_vld_i deasserted while tx_rdy_o=0 has no effect; no request queued.

Reset
REQ-028 With x_rst_i=1 at an edge, next cycle: state IDLE, tx_rdy_o=0, tx_dt_o=0, tx_ck_o=0, tx_done_o=0, tx_cnt_o=0.
REQ-029 tx_rdy_o=1 on the first cycle after x_rst_i deasserts.
REQ-030 Reset mid-frame aborts it at once: no tx_done_o pulse, no count increment, partial frame not resumed.

Verification
REQ-031 NLANE=1, tick=2, header 0xAA, data 0x08 -> N=17, 17 ck toggles 4 cycles apart, last bit (parity) 1, tx_done_o at A+69, tx_rdy_o at A+73.
REQ-032 NLANE=4, tick=2, header 0xEA, data 0x28 -> N=41, S=11, symbol0 dt=4'b1110, symbol10 dt=4'b1000 (parity 1, 3 pad zeros), tx_cnt_o=1.
REQ-033 NLANE=2, tick=0, header 0x80 -> H=1, S=5, symbol0 dt=2'b10, symbols1-3 2'b00, symbol4 2'b10, done at A+11.
REQ-034 tx_vld_i held high, three frames header 0x9A -> each N=9, gap exactly 2H cycles of dt=0, tx_cnt_o=3, tick_cfg_i change mid-frame ignored.
REQ-035 x_rst_i pulsed in symbol 5 of REQ-031 frame -> outputs per REQ-028 next cycle, no done pulse, tx_cnt_o=0, tx_rdy_o=1 after release.
REQ-036 Preload tx_cnt_o to 0xFFFF via 65535 frames (or forced state) -> next done gives 0x0000.
